wb_ps2_keyboard: RTL and testbench

Wishbone slave for the keyboard slot (slave index 3, `slave_STB[3]`) of the system interconnect. It receives PS/2 device-to-host frames, checks each frame, and queues valid scan-code bytes in a small FIFO. The CPU drains the FIFO and reads or clears status through single-cycle Wishbone reads and writes.

---
 rtl/wb_ps2_keyboard.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_wb_ps2_keyboard.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ps2_keyboard.sv
// ---------------------------------------------------------------------------
// wb_ps2_keyboard
//
// Wishbone slave for the keyboard slot. It receives PS/2 device-to-host
// frames and checks each one. Valid scan-code bytes are queued in a small
// FIFO. The CPU drains the FIFO through DATA reads and reads or clears
// sticky status through STATUS reads and writes.
//
// Ports
//   clk       system clock, all state on the rising edge
//   reset     synchronous, active-low reset
//   STB/WE    Wishbone strobe / write enable
//   ADDR      byte address, only ADDR[2] decoded (0 = DATA, 1 = STATUS)
//   DAT_I     write data (STATUS W1C: bit2 = overflow, bit3 = frame_err)
//   DAT_O     registered read data
//   ACK       registered one-cycle acknowledge
//   ps2_clk   raw PS/2 clock (asynchronous)
//   ps2_data  raw PS/2 data (asynchronous)
//   irq       high while the FIFO holds at least one byte
// ---------------------------------------------------------------------------
module wb_ps2_keyboard #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers. The idle level of the PS/2 lines is high, so the
    // flops reset to 1 and no falling edge is seen when reset releases.
    // ------------------------------------------------------------------
    logic ps2_clk_meta_q,  ps2_clk_meta_d;
    logic ps2_clk_sync_q,  ps2_clk_sync_d;
    logic ps2_clk_prev_q,  ps2_clk_prev_d;
    logic ps2_data_meta_q, ps2_data_meta_d;
    logic ps2_data_sync_q, ps2_data_sync_d;

    always_comb begin
        ps2_clk_meta_d  = ps2_clk;
        ps2_clk_sync_d  = ps2_clk_meta_q;
        ps2_clk_prev_d  = ps2_clk_sync_q;
        ps2_data_meta_d = ps2_data;
        ps2_data_sync_d = ps2_data_meta_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_prev_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= ps2_clk_meta_d;
            ps2_clk_sync_q  <= ps2_clk_sync_d;
            ps2_clk_prev_q  <= ps2_clk_prev_d;
            ps2_data_meta_q <= ps2_data_meta_d;
            ps2_data_sync_q <= ps2_data_sync_d;
        end
    end

    logic ps2_fall;
    logic rx_bit;
    assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_sync_q;
    assign rx_bit   = ps2_data_sync_q;

    // ------------------------------------------------------------------
    // Receiver FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    rx_state_t       state_q, state_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_hit;
    logic            frame_done;
    logic            frame_ok;
    logic            frame_bad;

    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ps2_fall && !rx_bit) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A falling edge takes precedence over an expiring timer:
                // the edge proves the device is still clocking.
                if (ps2_fall) begin
                    if (bitcnt_q == 4'd10) begin
                        state_d = ST_IDLE;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_done = (state_q == ST_SHIFT) && ps2_fall && (bitcnt_q == 4'd10);
        // Odd parity over data + parity bit, and the stop bit must be 1.
        frame_ok   = frame_done && rx_bit && (^{shift_q, parity_q});
        frame_bad  = frame_done && !frame_ok;
    end

    // Receiver datapath: bit counter, shift register, parity, timeout.
    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        to_cnt_d = '0;
        if (state_q == ST_IDLE) begin
            bitcnt_d = (ps2_fall && !rx_bit) ? 4'd1 : 4'd0;
        end else if (ps2_fall) begin
            if (bitcnt_q <= 4'd8) begin
                shift_d = {rx_bit, shift_q[7:1]};   // LSB arrives first
            end
            if (bitcnt_q == 4'd9) begin
                parity_d = rx_bit;
            end
            bitcnt_d = (bitcnt_q == 4'd10) ? 4'd0 : bitcnt_q + 4'd1;
        end else if (timeout_hit) begin
            bitcnt_d = 4'd0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bitcnt_q <= 4'd0;
            shift_q  <= 8'd0;
            parity_q <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus decode, FIFO control and sticky flags
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             frame_err_q, frame_err_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_o_q, dat_o_d;
    logic             irq_q, irq_d;

    logic        accept;
    logic        not_empty;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        ovf_set;
    logic [31:0] status_word;

    always_comb begin
        // ACK low is what re-arms acceptance, which gives one access per
        // two cycles and guarantees a single pop per accepted read.
        accept    = STB && !ack_q;
        not_empty = (count_q != '0);
        full      = (count_q == CNT_W'(DEPTH));
        pop       = accept && !WE && !ADDR[2] && not_empty;
        // A pop in the same cycle frees a slot, so a push into a full FIFO
        // that is being drained is kept rather than dropped.
        push_ok   = frame_ok && (!full || pop);
        ovf_set   = frame_ok && full && !pop;

        status_word                = '0;
        status_word[0]             = not_empty;
        status_word[1]             = full;
        status_word[2]             = overflow_q;
        status_word[3]             = frame_err_q;
        status_word[8 +: CNT_W]    = count_q;

        ack_d   = accept;
        dat_o_d = dat_o_q;
        if (accept && !WE) begin
            if (ADDR[2]) begin
                dat_o_d = status_word;
            end else if (not_empty) begin
                dat_o_d = {23'd0, 1'b1, fifo_mem_q[rd_ptr_q]};
            end else begin
                dat_o_d = '0;
            end
        end

        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        irq_d    = (count_d != '0);

        // Set wins over a simultaneous write-1-to-clear.
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        if (accept && WE && ADDR[2]) begin
            if (DAT_I[2]) overflow_d  = 1'b0;
            if (DAT_I[3]) frame_err_d = 1'b0;
        end
        if (ovf_set)   overflow_d  = 1'b1;
        if (frame_bad) frame_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ack_q       <= 1'b0;
            dat_o_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            ack_q       <= ack_d;
            dat_o_q     <= dat_o_d;
            irq_q       <= irq_d;
        end
    end

    // Storage array has no reset; entries are only read when count says
    // they were written.
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            fifo_mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign ACK   = ack_q;
    assign DAT_O = dat_o_q;
    assign irq   = irq_q;

    logic unused_bits;
    assign unused_bits = ^{ADDR[31:3], ADDR[1:0], DAT_I[31:4], DAT_I[1:0]};

endmodule

// File: tb/tb_wb_ps2_keyboard.sv
// ---------------------------------------------------------------------------
// tb_wb_ps2_keyboard
//
// Self-checking bench for wb_ps2_keyboard (DEPTH=8, short TIMEOUT).
// A constant vector table covers reset, single frame and error frames;
// hand-written sequences cover overflow, timeout, push/pop collision and
// back-to-back ACK; a randomized phase is checked against a queue model.
// ---------------------------------------------------------------------------
module tb_wb_ps2_keyboard;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    localparam int K_FRAME = 0;
    localparam int K_READ  = 1;
    localparam int K_WRITE = 2;
    localparam int K_IRQ   = 3;

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        STB      = 1'b0;
    logic        WE       = 1'b0;
    logic [31:0] ADDR     = 32'd0;
    logic [31:0] DAT_I    = 32'd0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    wire  [31:0] DAT_O;
    wire         ACK;
    wire         irq;

    int tests = 0;
    int fails = 0;

    wb_ps2_keyboard #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .reset    (reset),
        .STB      (STB),
        .WE       (WE),
        .ADDR     (ADDR),
        .DAT_I    (DAT_I),
        .DAT_O    (DAT_O),
        .ACK      (ACK),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          kind;
        logic [7:0]  b;
        bit          bad_par;
        bit          stop;
        bit          a2;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_ferr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %08h", name, act);
        end
    endtask

    function automatic void addv(input int kind, input logic [7:0] b, input bit bad_par,
                                 input bit stop, input bit a2, input logic [31:0] wd,
                                 input logic [31:0] exp, input string name);
        vec_t v;
        v.kind = kind; v.b = b; v.bad_par = bad_par; v.stop = stop;
        v.a2 = a2; v.wd = wd; v.exp = exp; v.name = name;
        vq.push_back(v);
    endfunction

    // One single-cycle bus access; called and returns at a negedge.
    task automatic bus(input bit we, input bit a2, input logic [31:0] wd,
                       output logic [31:0] rd);
        STB   = 1'b1;
        WE    = we;
        ADDR  = a2 ? 32'h4 : 32'h0;
        DAT_I = wd;
        @(negedge clk);
        chk("ack", {31'd0, ACK}, 32'd1);
        rd  = DAT_O;
        STB = 1'b0;
        WE  = 1'b0;
        @(negedge clk);
    endtask

    // One PS/2 bit. With align set, a DATA read is accepted on the same
    // clk edge that consumes this bit's falling edge (2 sync flops + 1).
    task automatic send_bit(input bit v, input bit align, output logic [31:0] rd);
        rd = 32'd0;
        ps2_data = v;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b0;
        if (align) begin
            repeat (2) @(negedge clk);
            STB  = 1'b1;
            WE   = 1'b0;
            ADDR = 32'h0;
            @(negedge clk);
            chk("ack_aligned", {31'd0, ACK}, 32'd1);
            rd  = DAT_O;
            STB = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        ps2_clk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                              input bit align, output logic [31:0] rd);
        logic [10:0] bits;
        logic [31:0] tmp;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        bits[9]   = (~^b) ^ bad_par;
        bits[10]  = stop;
        rd = 32'd0;
        for (int i = 0; i < 11; i++) begin
            send_bit(bits[i], align && (i == 10), tmp);
            if (i == 10) rd = tmp;
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'd0;
        s[0]    = (mq.size() != 0);
        s[1]    = (mq.size() == DEPTH);
        s[2]    = m_ovf;
        s[3]    = m_ferr;
        s[16:8] = 9'(mq.size());
        return s;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        if (!stop || bad_par) m_ferr = 1'b1;
        else if (mq.size() == DEPTH) m_ovf = 1'b1;
        else mq.push_back(b);
    endfunction

    initial begin
        logic [31:0] rd;
        logic [31:0] dummy;

        // ---------------- reset with STB held high ----------------
        @(negedge clk);
        reset = 1'b0;
        STB   = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ack",   {31'd0, ACK}, 32'd0);
        chk("reset_dat_o", DAT_O, 32'd0);
        chk("reset_irq",   {31'd0, irq}, 32'd0);
        STB   = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- vector table ----------------
        addv(K_READ,  8'h00, 0, 1, 1, 32'h0, 32'h00000000, "status_after_reset");
        addv(K_FRAME, 8'h1C, 0, 1, 0, 32'h0, 32'h0,        "frame_1c");
        addv(K_IRQ,   8'h00, 0, 1, 0, 32'h0, 32'h00000001, "irq_after_frame");
        addv(K_READ,  8'h00, 0, 1, 1, 32'h0, 32'h00000101, "status_one_entry");
        addv(K_READ,  8'h00, 0, 1, 0, 32'h0, 32'h0000011C, "data_1c");
        addv(K_READ,  8'h00, 0, 1, 1, 32'h0, 32'h00000000, "status_drained");
        addv(K_IRQ,   8'h00, 0, 1, 0, 32'h0, 32'h00000000, "irq_after_drain");
        addv(K_FRAME, 8'h1C, 1, 1, 0, 32'h0, 32'h0,        "frame_bad_parity");
        addv(K_READ,  8'h00, 0, 1, 1, 32'h0, 32'h00000008, "status_parity_err");
        addv(K_WRITE, 8'h00, 0, 1, 1, 32'h8, 32'h0,        "clear_frame_err");
        addv(K_READ,  8'h00, 0, 1, 1, 32'h0, 32'h00000000, "status_cleared");
        addv(K_FRAME, 8'h1C, 0, 0, 0, 32'h0, 32'h0,        "frame_bad_stop");
        addv(K_READ,  8'h00, 0, 1, 1, 32'h0, 32'h00000008, "status_stop_err");
        addv(K_WRITE, 8'h00, 0, 1, 0, 32'hFF, 32'h0,       "data_write_noop");
        addv(K_READ,  8'h00, 0, 1, 1, 32'h0, 32'h00000008, "status_after_data_wr");
        addv(K_WRITE, 8'h00, 0, 1, 1, 32'h8, 32'h0,        "clear_frame_err2");
        addv(K_READ,  8'h00, 0, 1, 1, 32'h0, 32'h00000000, "status_cleared2");
        addv(K_READ,  8'h00, 0, 1, 0, 32'h0, 32'h00000000, "data_empty");

        foreach (vq[i]) begin
            case (vq[i].kind)
                K_FRAME: send_frame(vq[i].b, vq[i].bad_par, vq[i].stop, 1'b0, dummy);
                K_READ: begin
                    bus(1'b0, vq[i].a2, 32'd0, rd);
                    chk(vq[i].name, rd, vq[i].exp);
                end
                K_WRITE: bus(1'b1, vq[i].a2, vq[i].wd, dummy);
                default: chk(vq[i].name, {31'd0, irq}, vq[i].exp);
            endcase
        end

        // ---------------- overflow ----------------
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b0, 1'b1, 1'b0, dummy);
        bus(1'b0, 1'b1, 32'd0, rd);
        chk("status_overflow", rd, 32'h00000807);
        for (int k = 1; k <= 8; k++) begin
            bus(1'b0, 1'b0, 32'd0, rd);
            chk($sformatf("ovf_data_%0d", k), rd, 32'h100 | 32'(k));
        end
        bus(1'b0, 1'b0, 32'd0, rd);
        chk("ovf_data_empty", rd, 32'h0);
        bus(1'b1, 1'b1, 32'h4, dummy);
        bus(1'b0, 1'b1, 32'd0, rd);
        chk("status_ovf_cleared", rd, 32'h0);

        // ---------------- timeout ----------------
        send_bit(1'b0, 1'b0, dummy);
        for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0, dummy);
        repeat (TIMEOUT + 10) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, dummy);
        bus(1'b0, 1'b1, 32'd0, rd);
        chk("timeout_status", rd, 32'h00000101);
        bus(1'b0, 1'b0, 32'd0, rd);
        chk("timeout_data", rd, 32'h0000015A);

        // ---------------- push/pop in the same cycle ----------------
        send_frame(8'h33, 1'b0, 1'b1, 1'b0, dummy);
        send_frame(8'h44, 1'b0, 1'b1, 1'b1, rd);
        chk("collide_pop", rd, 32'h00000133);
        bus(1'b0, 1'b1, 32'd0, rd);
        chk("collide_status", rd, 32'h00000101);
        bus(1'b0, 1'b0, 32'd0, rd);
        chk("collide_data", rd, 32'h00000144);
        // empty FIFO: the read sees nothing, the pushed byte stays
        send_frame(8'h21, 1'b0, 1'b1, 1'b1, rd);
        chk("collide_empty_pop", rd, 32'h0);
        bus(1'b0, 1'b0, 32'd0, rd);
        chk("collide_empty_data", rd, 32'h00000121);

        // ---------------- back-to-back with STB held ----------------
        STB  = 1'b1;
        WE   = 1'b0;
        ADDR = 32'h4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ack_%0d", k), {31'd0, ACK}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        STB = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- mid-run reset ----------------
        send_frame(8'h77, 1'b0, 1'b1, 1'b0, dummy);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_irq", {31'd0, irq}, 32'd0);
        bus(1'b0, 1'b1, 32'd0, rd);
        chk("midreset_status", rd, 32'h0);

        // ---------------- randomized against the queue model ----------------
        mq.delete();
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 5) begin
                logic [7:0] b;
                bit bp, st;
                b  = 8'($urandom);
                bp = ($urandom_range(0, 5) == 0);
                st = ($urandom_range(0, 5) != 0);
                send_frame(b, bp, st, 1'b0, dummy);
                model_frame(b, bp, st);
                $display("[TB] frame %02h bad_par=%0d stop=%0d", b, bp, st);
            end else if (op < 7) begin
                logic [31:0] exp;
                exp = 32'd0;
                if (mq.size() != 0) exp = {23'd0, 1'b1, mq.pop_front()};
                bus(1'b0, 1'b0, 32'd0, rd);
                chk("rand_data", rd, exp);
            end else if (op < 9) begin
                logic [31:0] exp;
                exp = model_status();
                bus(1'b0, 1'b1, 32'd0, rd);
                chk("rand_status", rd, exp);
            end else begin
                logic [31:0] wd;
                wd = $urandom;
                bus(1'b1, 1'b1, wd, dummy);
                if (wd[2]) m_ovf  = 1'b0;
                if (wd[3]) m_ferr = 1'b0;
                $display("[TB] status write %08h", wd);
            end
            chk("rand_irq", {31'd0, irq}, {31'd0, mq.size() != 0});
        end
        bus(1'b0, 1'b1, 32'd0, rd);
        chk("rand_final_status", rd, model_status());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
